pwm_duty_sequencer: RTL and testbench

Upstream stage of the 4-bit PWM generator: produces the duty_cycle word that the PWM stage compares against its free-running counter.
- Supports hold, ramp-up, ramp-down and triangle "breathe" profiles.
- Step rate is programmable in PWM periods.
- duty_cycle changes only at PWM period boundaries (period_tick from the PWM stage), so no period ever sees a mid-period duty change.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_step_timer.sv | 19 +
 rtl/pwm_duty_sequencer.sv | 94 +++++++++
 tb/tb_pwm_duty_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM duty sequencer and PWM stage.
package pwm_pkg;
  localparam int DUTY_W_DEFAULT = 4;
  localparam int DUTY_MAX = (1 << DUTY_W_DEFAULT) - 1;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_UP, S_DOWN, S_PEAK, S_TROUGH} state_t;
endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer: counts PWM periods and fires a step every rate+1 ticks.
module pwm_step_timer #(
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);
  logic [RATE_W-1:0] pcnt;
  // >= keeps the counter from running past a freshly lowered rate
  assign step = tick && !clear && pcnt >= rate;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) pcnt <= '0;
    else if (clear) pcnt <= '0;
    else if (tick) pcnt <= step ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: period-aligned duty word sequencer (hold, ramp up/down, breathe)
// feeding the PWM stage; duty only changes on the cycle after a period_tick.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEFAULT,
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [RATE_W-1:0] rate,
  input  logic [DUTY_W-1:0] duty_set,
  input  logic              period_tick,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              step_strobe,
  output logic              at_limit
);
  localparam logic [DUTY_W-1:0] MAX = '1;
  localparam logic [DUTY_W-1:0] ZERO = '0;
  state_t state, state_n;
  logic [1:0] cur_mode, cur_mode_n;
  logic [DUTY_W-1:0] duty_n;
  logic strobe_n, step, load, breathe;
  assign load = period_tick && (state == S_IDLE || mode != cur_mode);
  assign breathe = cur_mode == MODE_BREATHE;
  pwm_step_timer #(.RATE_W(RATE_W)) u_timer (
    .clk(clk),
    .resetn(resetn),
    .tick(period_tick),
    .clear(!en || load),
    .rate(rate),
    .step(step)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      cur_mode <= MODE_HOLD;
      duty_cycle <= '0;
      step_strobe <= 1'b0;
    end else begin
      state <= state_n;
      cur_mode <= cur_mode_n;
      duty_cycle <= duty_n;
      step_strobe <= strobe_n;
    end
  always_comb begin
    state_n = state;
    cur_mode_n = cur_mode;
    duty_n = duty_cycle;
    strobe_n = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      duty_n = ZERO;
    end else if (load) begin
      // breathe entered mid-run continues from the current value
      cur_mode_n = mode;
      state_n = mode == MODE_HOLD ? S_HOLD :
                mode == MODE_DOWN ? S_DOWN :
                (mode == MODE_BREATHE && state != S_IDLE && duty_cycle == MAX) ? S_DOWN : S_UP;
      duty_n = mode != MODE_BREATHE ? duty_set : state == S_IDLE ? ZERO : duty_cycle;
    end else if (period_tick && state == S_HOLD) begin
      duty_n = duty_set;
    end else if (step) begin
      case (state)
        S_UP:
          if (duty_cycle != MAX) begin
            duty_n = duty_cycle + 1'b1;
            strobe_n = 1'b1;
          end else if (breathe) state_n = S_PEAK;
        S_DOWN:
          if (duty_cycle != ZERO) begin
            duty_n = duty_cycle - 1'b1;
            strobe_n = 1'b1;
          end else if (breathe) state_n = S_TROUGH;
        S_PEAK: begin
          state_n = S_DOWN;
          duty_n = duty_cycle - 1'b1;
          strobe_n = 1'b1;
        end
        S_TROUGH: begin
          state_n = S_UP;
          duty_n = duty_cycle + 1'b1;
          strobe_n = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_comb
    at_limit = (state == S_UP && cur_mode == MODE_UP && duty_cycle == MAX) ||
               (state == S_DOWN && cur_mode == MODE_DOWN && duty_cycle == ZERO);
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed and randomized checks against a period-level behavioural model.
module tb_pwm_duty_sequencer;
  logic clk = 1'b0, resetn = 1'b0, en = 1'b0, period_tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] rate = 4'd0, duty_set = 4'd0;
  logic [3:0] duty_cycle;
  logic step_strobe, at_limit;
  int checks = 0, failures = 0, strobes = 0;
  bit m_run = 0, m_strobe = 0;
  logic [1:0] m_mode = 2'd0;
  int m_duty = 0, m_n = 0, m_phase = 0;
  always #5 clk = ~clk;
  pwm_duty_sequencer dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .mode(mode),
    .rate(rate),
    .duty_set(duty_set),
    .period_tick(period_tick),
    .duty_cycle(duty_cycle),
    .step_strobe(step_strobe),
    .at_limit(at_limit)
  );
  // triangle position k in a 32-period breathe cycle
  function automatic int bval(input int k);
    return k < 16 ? k : (k == 16 ? 15 : 31 - k);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model(input bit t);
    int old;
    m_strobe = 0;
    if (!en) begin
      m_run = 0;
      m_duty = 0;
    end else if (t) begin
      if (!m_run || mode != m_mode) begin
        m_phase = (mode == 2'd3 && m_run) ? (m_duty == 15 ? 16 : m_duty) : 0;
        if (mode != 2'd3) m_duty = int'(duty_set);
        else if (!m_run) m_duty = 0;
        m_run = 1;
        m_mode = mode;
        m_n = 0;
      end else begin
        m_n++;
        if (m_mode == 2'd0) m_duty = int'(duty_set);
        else if (m_n % (int'(rate) + 1) == 0) begin
          old = m_duty;
          if (m_mode == 2'd1) m_duty = old == 15 ? 15 : old + 1;
          else if (m_mode == 2'd2) m_duty = old == 0 ? 0 : old - 1;
          else begin
            m_phase = (m_phase + 1) % 32;
            m_duty = bval(m_phase);
          end
          m_strobe = m_duty != old;
        end
      end
    end
  endtask
  task automatic cyc(input bit t);
    bit lim;
    period_tick = t;
    model(t);
    @(posedge clk);
    #1;
    period_tick = 1'b0;
    lim = m_run && ((m_mode == 2'd1 && m_duty == 15) || (m_mode == 2'd2 && m_duty == 0));
    check("duty", duty_cycle, m_duty);
    check("strobe", step_strobe, m_strobe);
    check("at_limit", at_limit, lim);
    if (step_strobe) strobes++;
  endtask
  task automatic tick(input int gap);
    cyc(1);
    repeat (gap - 1) cyc(0);
  endtask
  task automatic restart(input logic [1:0] md, input logic [3:0] ds, input logic [3:0] rt);
    en = 1'b0;
    cyc(0);
    mode = md;
    duty_set = ds;
    rate = rt;
    en = 1'b1;
  endtask
  initial begin
    #12;
    check("reset_duty", duty_cycle, 0);
    check("reset_strobe", step_strobe, 0);
    check("reset_limit", at_limit, 0);
    resetn = 1'b1;
    repeat (3) cyc(1);
    en = 1'b1;
    repeat (3) cyc(0);
    // hold, with a duty_set change between ticks
    mode = 2'd0;
    duty_set = 4'd6;
    tick(16);
    check("hold_6", duty_cycle, 6);
    duty_set = 4'd11;
    tick(16);
    tick(16);
    check("hold_11", duty_cycle, 11);
    // ramp up saturating at max
    restart(2'd1, 4'd12, 4'd1);
    strobes = 0;
    repeat (18) tick($urandom_range(1, 4));
    check("up_sat", duty_cycle, 15);
    check("up_limit", at_limit, 1);
    check("up_strobes", strobes, 3);
    // ramp down saturating at zero
    restart(2'd2, 4'd2, 4'd0);
    repeat (8) tick($urandom_range(1, 4));
    check("down_sat", duty_cycle, 0);
    check("down_limit", at_limit, 1);
    // breathe two full cycles
    restart(2'd3, 4'd9, 4'd0);
    strobes = 0;
    repeat (64) tick($urandom_range(1, 3));
    check("breathe_strobes", strobes, 60);
    // en drop together with a tick at duty 7
    restart(2'd1, 4'd4, 4'd0);
    repeat (4) tick(2);
    check("pre_drop", duty_cycle, 7);
    en = 1'b0;
    cyc(1);
    check("drop_duty", duty_cycle, 0);
    en = 1'b1;
    repeat (3) cyc(0);
    // mode changes while running
    restart(2'd1, 4'd3, 4'd2);
    repeat (7) tick(2);
    mode = 2'd3;
    repeat (40) tick($urandom_range(1, 3));
    mode = 2'd2;
    repeat (10) tick(2);
    restart(2'd1, 4'd13, 4'd0);
    repeat (5) tick(1);
    mode = 2'd3;
    repeat (10) tick(2);
    // rate 15 with back-to-back ticks
    restart(2'd1, 4'd0, 4'd15);
    strobes = 0;
    repeat (49) tick(1);
    check("rate15_strobes", strobes, 3);
    check("rate15_duty", duty_cycle, 3);
    // async reset mid-breathe
    restart(2'd3, 4'd0, 4'd0);
    repeat (10) tick(2);
    check("pre_reset", duty_cycle, 9);
    #3;
    resetn = 1'b0;
    #1;
    check("async_duty", duty_cycle, 0);
    check("async_strobe", step_strobe, 0);
    check("async_limit", at_limit, 0);
    m_run = 0;
    m_duty = 0;
    #2;
    resetn = 1'b1;
    repeat (3) cyc(0);
    repeat (4) tick(2);
    // randomized mode sequences
    for (int s = 0; s < 12; s++) begin
      if (s % 3 == 0) restart(mode, duty_set, 4'($urandom_range(0, 3)));
      mode = mode + 2'($urandom_range(1, 3));
      duty_set = 4'($urandom_range(0, 15));
      repeat ($urandom_range(5, 25)) begin
        tick($urandom_range(1, 4));
        duty_set = 4'($urandom_range(0, 15));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
